cgra_host_loader: RTL and testbench

// Host-side initiator for the CGRA core's configuration/data interface. Consumes one-beat commands
// (valid/ready), drives the CTX_RC/CTX_PE/CTX_IM/LDM write ports, pulses start and waits for complete,

---
 rtl/cgra_host_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_cgra_host_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cgra_host_loader.sv
// Host-side command loader for the CGRA core: writes context/LDM memories, runs the core,
// reads LDM words back and returns exactly one response beat per accepted command.
module cgra_host_loader #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 2,
    parameter int GUARD     = 4,
    parameter int TIMEOUT_W = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid_in,
    output logic              cmd_ready_out,
    input  logic [2:0]        cmd_op_in,
    input  logic [ADDR_W-1:0] cmd_addr_in,
    input  logic [DATA_W-1:0] cmd_data_in,
    output logic              rsp_valid_out,
    input  logic              rsp_ready_in,
    output logic [DATA_W-1:0] rsp_data_out,
    output logic              rsp_err_out,
    output logic [ADDR_W-1:0] CTX_RC_addra_out,
    output logic [DATA_W-1:0] CTX_RC_dina_out,
    output logic              CTX_RC_ena_out,
    output logic              CTX_RC_wea_out,
    output logic [ADDR_W-1:0] CTX_PE_addra_out,
    output logic [DATA_W-1:0] CTX_PE_dina_out,
    output logic              CTX_PE_ena_out,
    output logic              CTX_PE_wea_out,
    output logic [ADDR_W-1:0] CTX_IM_addra_out,
    output logic [DATA_W-1:0] CTX_IM_dina_out,
    output logic              CTX_IM_ena_out,
    output logic              CTX_IM_wea_out,
    output logic [ADDR_W-1:0] LDM_addra_out,
    output logic [DATA_W-1:0] LDM_dina_out,
    output logic              LDM_ena_out,
    output logic              LDM_wea_out,
    input  logic [DATA_W-1:0] LDM_douta_in,
    output logic              start_out,
    input  logic              complete_in,
    output logic              busy_out
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_CMPL = 3'd3,
        ST_RD_ISSUE  = 3'd4,
        ST_RD_WAIT   = 3'd5,
        ST_RSP       = 3'd6
    } state_t;

    localparam logic [DATA_W-1:0]    GUARD_C  = DATA_W'(GUARD);
    localparam logic [2:0]           RD_LAT_C = 3'(RD_LAT);
    localparam logic [DATA_W-1:0]    CNT_ONE  = DATA_W'(1);
    localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

    state_t                state_r, state_s;
    logic                  ready_r, busy_r, rsp_valid_r, start_r, start_s;
    logic                  rsp_err_r, rsp_err_s;
    logic [DATA_W-1:0]     rsp_data_r, rsp_data_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_W-1:0]     data_r;
    logic [DATA_W-1:0]     cnt_r, cnt_s;
    logic [TIMEOUT_W-1:0]  tmo_r, tmo_s;
    logic [2:0]            rdc_r, rdc_s;
    // port index: 0 RC, 1 PE, 2 IM, 3 LDM
    logic [3:0]            ena_r, ena_s, wea_r, wea_s;
    logic                  accept_s;

    assign accept_s = cmd_valid_in & ready_r;

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_s    = state_r;
        ena_s      = 4'b0000;
        wea_s      = 4'b0000;
        start_s    = 1'b0;
        cnt_s      = cnt_r;
        tmo_s      = tmo_r;
        rdc_s      = rdc_r;
        rsp_data_s = rsp_data_r;
        rsp_err_s  = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op_in)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_s                = ST_WRITE;
                            ena_s[cmd_op_in[1:0]]  = 1'b1;
                            wea_s[cmd_op_in[1:0]]  = 1'b1;
                        end
                        3'd4: begin
                            state_s = ST_START;
                            start_s = 1'b1;
                            cnt_s   = '0;
                            tmo_s   = '0;
                        end
                        3'd5: begin
                            state_s  = ST_RD_ISSUE;
                            ena_s[3] = 1'b1;
                        end
                        default: begin
                            state_s    = ST_RSP;
                            rsp_data_s = '0;
                            rsp_err_s  = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_s    = ST_RSP;
                rsp_data_s = '0;
                rsp_err_s  = 1'b0;
            end
            ST_START: begin
                state_s = ST_WAIT_CMPL;
            end
            ST_WAIT_CMPL: begin
                // cnt_s equals the number of cycles elapsed since the start pulse
                cnt_s = (cnt_r == {DATA_W{1'b1}}) ? cnt_r : cnt_r + CNT_ONE;
                tmo_s = tmo_r + TMO_ONE;
                if (complete_in && (cnt_r >= GUARD_C)) begin
                    state_s    = ST_RSP;
                    rsp_data_s = cnt_s;
                    rsp_err_s  = 1'b0;
                end else if (tmo_s == {TIMEOUT_W{1'b1}}) begin
                    state_s    = ST_RSP;
                    rsp_data_s = cnt_s;
                    rsp_err_s  = 1'b1;
                end else begin
                    state_s = ST_WAIT_CMPL;
                end
            end
            ST_RD_ISSUE: begin
                state_s = ST_RD_WAIT;
                rdc_s   = 3'd1;
            end
            ST_RD_WAIT: begin
                if (rdc_r == RD_LAT_C) begin
                    state_s    = ST_RSP;
                    rsp_data_s = LDM_douta_in;
                    rsp_err_s  = 1'b0;
                end else begin
                    rdc_s = rdc_r + 3'd1;
                end
            end
            ST_RSP: begin
                if (rsp_ready_in) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs and captured command fields.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            start_r     <= 1'b0;
            ena_r       <= 4'b0000;
            wea_r       <= 4'b0000;
            cnt_r       <= '0;
            tmo_r       <= '0;
            rdc_r       <= 3'd0;
            addr_r      <= '0;
            data_r      <= '0;
        end else begin
            state_r     <= state_s;
            ready_r     <= (state_s == ST_IDLE);
            busy_r      <= (state_s != ST_IDLE);
            rsp_valid_r <= (state_s == ST_RSP);
            rsp_data_r  <= rsp_data_s;
            rsp_err_r   <= rsp_err_s;
            start_r     <= start_s;
            ena_r       <= ena_s;
            wea_r       <= wea_s;
            cnt_r       <= cnt_s;
            tmo_r       <= tmo_s;
            rdc_r       <= rdc_s;
            if (accept_s) begin
                addr_r <= cmd_addr_in;
                data_r <= cmd_data_in;
            end else begin
                addr_r <= addr_r;
                data_r <= data_r;
            end
        end
    end

    assign cmd_ready_out    = ready_r;
    assign busy_out         = busy_r;
    assign rsp_valid_out    = rsp_valid_r;
    assign rsp_data_out     = rsp_data_r;
    assign rsp_err_out      = rsp_err_r;
    assign start_out        = start_r;
    // Address/data are shared; only the enabled port acts on them.
    assign CTX_RC_addra_out = addr_r;
    assign CTX_RC_dina_out  = data_r;
    assign CTX_RC_ena_out   = ena_r[0];
    assign CTX_RC_wea_out   = wea_r[0];
    assign CTX_PE_addra_out = addr_r;
    assign CTX_PE_dina_out  = data_r;
    assign CTX_PE_ena_out   = ena_r[1];
    assign CTX_PE_wea_out   = wea_r[1];
    assign CTX_IM_addra_out = addr_r;
    assign CTX_IM_dina_out  = data_r;
    assign CTX_IM_ena_out   = ena_r[2];
    assign CTX_IM_wea_out   = wea_r[2];
    assign LDM_addra_out    = addr_r;
    assign LDM_dina_out     = data_r;
    assign LDM_ena_out      = ena_r[3];
    assign LDM_wea_out      = wea_r[3];

endmodule

// File: tb/tb_cgra_host_loader.sv
// Self-checking bench for cgra_host_loader: directed scenarios followed by random commands,
// checked against a rule-level model of memory contents and run/timeout timing.
module tb_cgra_host_loader;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int GD = 4;
    localparam int TW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic          cmd_valid = 1'b0, cmd_ready_out;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid_out, rsp_err_out, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data_out;
    logic [AW-1:0] rc_a, pe_a, im_a, ldm_a;
    logic [DW-1:0] rc_d, pe_d, im_d, ldm_d, ldm_q;
    logic          rc_e, rc_w, pe_e, pe_w, im_e, im_w, ldm_e, ldm_w;
    logic          start_out, busy_out, complete = 1'b0;

    cgra_host_loader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .GUARD(GD), .TIMEOUT_W(TW)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready_out), .cmd_op_in(cmd_op),
        .cmd_addr_in(cmd_addr), .cmd_data_in(cmd_data),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready),
        .rsp_data_out(rsp_data_out), .rsp_err_out(rsp_err_out),
        .CTX_RC_addra_out(rc_a), .CTX_RC_dina_out(rc_d), .CTX_RC_ena_out(rc_e), .CTX_RC_wea_out(rc_w),
        .CTX_PE_addra_out(pe_a), .CTX_PE_dina_out(pe_d), .CTX_PE_ena_out(pe_e), .CTX_PE_wea_out(pe_w),
        .CTX_IM_addra_out(im_a), .CTX_IM_dina_out(im_d), .CTX_IM_ena_out(im_e), .CTX_IM_wea_out(im_w),
        .LDM_addra_out(ldm_a), .LDM_dina_out(ldm_d), .LDM_ena_out(ldm_e), .LDM_wea_out(ldm_w),
        .LDM_douta_in(ldm_q), .start_out(start_out), .complete_in(complete), .busy_out(busy_out)
    );

    logic [3:0] ena_v, wea_v;
    assign ena_v = {ldm_e, im_e, pe_e, rc_e};
    assign wea_v = {ldm_w, im_w, pe_w, rc_w};
    logic [236:0] all_outs;
    assign all_outs = {cmd_ready_out, rsp_valid_out, rsp_data_out, rsp_err_out,
                       rc_a, rc_d, rc_e, rc_w, pe_a, pe_d, pe_e, pe_w,
                       im_a, im_d, im_e, im_w, ldm_a, ldm_d, ldm_e, ldm_w, start_out, busy_out};

    // LDM environment: synchronous RAM with RL-cycle read latency, noise when no read is due.
    logic [DW-1:0] env_mem [0:255];
    logic [DW-1:0] pd [RL];
    logic          pv [RL];
    logic [DW-1:0] junk;
    always @(posedge CLK) begin
        if (ldm_e && ldm_w) env_mem[ldm_a[7:0]] <= ldm_d;
        pv[0] <= ldm_e && !ldm_w;
        pd[0] <= env_mem[ldm_a[7:0]];
        for (int i = 1; i < RL; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
        junk <= $urandom;
    end
    assign ldm_q = (pv[RL-1] === 1'b1) ? pd[RL-1] : junk;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] ref_mem [int];
    int written [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (cmd_ready_out !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("cmd_ready", cmd_ready_out, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(negedge CLK);
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_addr = AW'($urandom); cmd_data = $urandom;
    endtask

    task automatic take_rsp(input string tag, input logic [DW-1:0] exp_d, input logic exp_e, input int stall);
        int n = 0;
        while (rsp_valid_out !== 1'b1 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "/rsp_valid"}, rsp_valid_out, 1'b1);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "/held"}, {rsp_valid_out, cmd_ready_out, rsp_err_out, rsp_data_out},
                {1'b1, 1'b0, exp_e, exp_d});
            @(negedge CLK);
        end
        chk({tag, "/rsp"}, {rsp_err_out, rsp_data_out}, {exp_e, exp_d});
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        chk({tag, "/post"}, {rsp_valid_out, cmd_ready_out, busy_out}, 3'b010);
    endtask

    task automatic do_write(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
        logic [3:0] oh;
        logic [AW+DW-1:0] ad;
        oh = 4'b0001 << op[1:0];
        issue(op, a, d);
        chk("wr/ena", {ena_v, wea_v, start_out}, {oh, oh, 1'b0});
        case (op[1:0])
            2'd0:    ad = {rc_a, rc_d};
            2'd1:    ad = {pe_a, pe_d};
            2'd2:    ad = {im_a, im_d};
            default: ad = {ldm_a, ldm_d};
        endcase
        chk("wr/addr_data", ad, {a, d});
        if (op == 3'd3) begin
            if (!ref_mem.exists(int'(a))) written.push_back(int'(a));
            ref_mem[int'(a)] = d;
        end
        @(negedge CLK);
        chk("wr/ena_off", {ena_v, wea_v}, 8'h00);
        take_rsp("wr", '0, 1'b0, stall);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int stall);
        issue(3'd5, a, '0);
        chk("rd/issue", {ena_v, wea_v, start_out, ldm_a}, {4'b1000, 4'b0000, 1'b0, a});
        @(negedge CLK);
        chk("rd/ena_off", ena_v, 4'b0000);
        take_rsp("rd", ref_mem[int'(a)], 1'b0, stall);
    endtask

    task automatic do_illegal(input logic [2:0] op, input int stall);
        issue(op, AW'($urandom), $urandom);
        chk("ill/quiet", {ena_v, wea_v, start_out, rsp_valid_out}, {9'b0, 1'b1});
        take_rsp("ill", '0, 1'b1, stall);
    endtask

    // complete_in is high for cycle offsets k < drop and k >= rise, counted from the start pulse.
    task automatic do_run(input int drop, input int rise, input int stall);
        int exp_d = 0;
        logic exp_e = 1'b0;
        int k = 0;
        int extra_start = 0;
        for (int c = 1; c <= 255; c++) begin
            if (c > GD && (c < drop || c >= rise)) begin
                exp_d = c; exp_e = 1'b0; break;
            end
            if (c == 255) begin
                exp_d = 255; exp_e = 1'b1;
            end
        end
        issue(3'd4, AW'($urandom), $urandom);
        chk("run/start", {start_out, ena_v, wea_v}, {1'b1, 8'h00});
        while (k < 400) begin
            complete = (k < drop) || (k >= rise);
            @(negedge CLK);
            k++;
            if (start_out !== 1'b0) extra_start++;
            if (rsp_valid_out === 1'b1) break;
        end
        chk("run/start_once", extra_start, 0);
        take_rsp("run", DW'(exp_d), exp_e, stall);
    endtask

    initial begin
        int op, a, n_rand;
        #12;
        chk("reset/outs", all_outs, '0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("reset/ready", {cmd_ready_out, rsp_valid_out, busy_out}, 3'b100);

        do_write(3'd1, 16'h0012, 32'hDEADBEEF, 0);
        do_write(3'd3, 16'h0005, 32'h00001234, 0);
        do_read(16'h0005, 0);
        complete = 1'b1;
        repeat (3) @(negedge CLK);
        do_run(2, 100, 0);
        do_run(0, 1000, 1);
        do_illegal(3'd7, 5);
        do_illegal(3'd6, 0);
        do_write(3'd0, 16'hFFFF, 32'h0, 0);
        do_write(3'd2, 16'h0000, 32'hFFFFFFFF, 0);
        do_run(0, 5, 0);
        do_run(0, 3, 0);

        // reset in the middle of a run aborts it without a response
        issue(3'd4, 16'h0, 32'h0);
        complete = 1'b0;
        repeat (20) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrun_rst/outs", all_outs, '0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrun_rst/after", {cmd_ready_out, rsp_valid_out, busy_out, start_out}, 4'b1000);

        n_rand = 40;
        for (int i = 0; i < n_rand; i++) begin
            op = $urandom_range(0, 7);
            if (op == 5 && written.size() == 0) op = 3;
            case (op)
                0, 1, 2: do_write(3'(op), AW'($urandom), $urandom, $urandom_range(0, 2));
                3: do_write(3'd3, AW'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2));
                4: do_run($urandom_range(0, 3),
                          ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(1, 60),
                          $urandom_range(0, 2));
                5: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    do_read(AW'(a), $urandom_range(0, 2));
                end
                default: do_illegal(3'(op), $urandom_range(0, 2));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
